// File: rtl/ram_arb_2p.sv
// Two-requester round-robin arbiter and sequencer in front of the single-port ram_4x4.
// Grants one single-beat command per cycle and returns read data two cycles after acceptance.
module ram_arb_2p #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          WR0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] D0,
    output logic          GNT0,
    output logic          RVALID0,
    output logic [DW-1:0] RDATA0,
    input  logic          REQ1,
    input  logic          WR1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] D1,
    output logic          GNT1,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA1,
    output logic          MEM_EN,
    output logic          MEM_WR,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_D,
    input  logic [DW-1:0] MEM_Q
);

    logic          r_last;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_a;
    logic [DW-1:0] r_mem_d;
    logic          r_tag1_v;
    logic          r_tag1_src;
    logic          r_tag2_v;
    logic          r_tag2_src;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_src;
    logic          w_wr;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!RST) begin
            w_gnt0 = REQ0 & (~REQ1 | r_last);
            w_gnt1 = REQ1 & (~REQ0 | ~r_last);
        end
        w_any = w_gnt0 | w_gnt1;
        w_src = w_gnt1;
        w_wr  = w_gnt1 ? WR1 : WR0;
        w_a   = w_gnt1 ? A1  : A0;
        w_d   = w_gnt1 ? D1  : D0;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last     <= 1'b1;
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_tag1_v   <= 1'b0;
            r_tag1_src <= 1'b0;
            r_tag2_v   <= 1'b0;
            r_tag2_src <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_mem_en <= w_any;
            // Command fields hold on idle cycles; only MEM_EN marks a live command.
            if (w_any) begin
                r_mem_wr <= w_wr;
                r_mem_a  <= w_a;
                r_mem_d  <= w_d;
                r_last   <= w_src;
            end
            r_tag1_v   <= w_any & ~w_wr;
            r_tag1_src <= w_src;
            r_tag2_v   <= r_tag1_v;
            r_tag2_src <= r_tag1_src;
            r_rvalid0  <= r_tag2_v & ~r_tag2_src;
            r_rvalid1  <= r_tag2_v &  r_tag2_src;
            if (r_tag2_v && !r_tag2_src) r_rdata0 <= MEM_Q;
            if (r_tag2_v &&  r_tag2_src) r_rdata1 <= MEM_Q;
        end
    end

    assign GNT0    = w_gnt0;
    assign GNT1    = w_gnt1;
    assign RVALID0 = r_rvalid0;
    assign RVALID1 = r_rvalid1;
    assign RDATA0  = r_rdata0;
    assign RDATA1  = r_rdata1;
    assign MEM_EN  = r_mem_en;
    assign MEM_WR  = r_mem_wr;
    assign MEM_A   = r_mem_a;
    assign MEM_D   = r_mem_d;

endmodule

// File: tb/tb_ram_arb_2p.sv
// Bench for ram_arb_2p: behavioural RAM, directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_ram_arb_2p;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          CLK;
    logic          RST;
    logic          REQ0, WR0, REQ1, WR1;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, D1;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [DW-1:0] RDATA0, RDATA1;
    logic          MEM_EN, MEM_WR;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_D;
    logic [DW-1:0] MEM_Q;

    int n_checks = 0;
    int n_fail   = 0;

    ram_arb_2p #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WR0(WR0), .A0(A0), .D0(D0),
        .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WR1(WR1), .A1(A1), .D1(D1),
        .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
        .MEM_EN(MEM_EN), .MEM_WR(MEM_WR), .MEM_A(MEM_A), .MEM_D(MEM_D),
        .MEM_Q(MEM_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ram_4x4: write or read at the edge, Q valid the following cycle.
    logic [DW-1:0] ram [16];
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WR) ram[MEM_A] <= MEM_D;
            else        MEM_Q <= ram[MEM_A];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic          src;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] shadow [16];
    bit            started = 0;
    int            m_edge  = 0;
    logic          m_last;
    logic          e_en, e_wr, e_rv0, e_rv1;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_rd0, e_rd1;

    always @(negedge CLK) begin
        logic want0, want1, win, granted;
        if (started) begin
            check("mem_en",  MEM_EN,  e_en);
            check("mem_wr",  MEM_WR,  e_wr);
            check("mem_a",   MEM_A,   e_a);
            check("mem_d",   MEM_D,   e_d);
            check("rvalid0", RVALID0, e_rv0);
            check("rvalid1", RVALID1, e_rv1);
            check("rdata0",  RDATA0,  e_rd0);
            check("rdata1",  RDATA1,  e_rd1);
        end
        m_edge++;
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (RST) begin
            check("gnt0_rst", GNT0, 1'b0);
            check("gnt1_rst", GNT1, 1'b0);
            pend.delete();
            m_last = 1'b1;
            e_en = 1'b0; e_wr = 1'b0; e_a = '0; e_d = '0;
            e_rd0 = '0; e_rd1 = '0;
            started = 1;
        end else if (started) begin
            want0 = REQ0;
            want1 = REQ1;
            // Contention goes to whoever did not win most recently.
            granted = want0 | want1;
            win     = (want0 && want1) ? ~m_last : want1;
            check("gnt0", GNT0, granted & ~win);
            check("gnt1", GNT1, granted &  win);
            if (pend.size() > 0 && pend[0].due == m_edge) begin
                if (pend[0].src) begin e_rv1 = 1'b1; e_rd1 = pend[0].data; end
                else             begin e_rv0 = 1'b1; e_rd0 = pend[0].data; end
                void'(pend.pop_front());
            end
            e_en = granted;
            if (granted) begin
                m_last = win;
                e_wr = win ? WR1 : WR0;
                e_a  = win ? A1  : A0;
                e_d  = win ? D1  : D0;
                if (e_wr) shadow[e_a] = e_d;
                else      pend.push_back('{src: win, data: shadow[e_a], due: m_edge + 2});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic g0, g1;

    task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        REQ0 = r0; WR0 = w0; A0 = a0; D0 = d0;
        REQ1 = r1; WR1 = w1; A1 = a1; D1 = d1;
        #2;
        g0 = GNT0;
        g1 = GNT1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) idle();
        RST = 1'b0;
    endtask

    initial begin
        logic [5:0] seq0, seq1;
        RST = 1'b1;
        REQ0 = 0; WR0 = 0; A0 = 0; D0 = 0;
        REQ1 = 0; WR1 = 0; A1 = 0; D1 = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i]    = 4'($urandom);
            shadow[i] = ram[i];
        end
        do_reset(2);

        // Single write from requester 0.
        cyc(1, 1, 4'd11, 4'd3, 0, 0, 0, 0);
        check("t1_gnt0", g0, 1'b1);
        check("t1_mem_en", MEM_EN, 1'b1);
        check("t1_mem_wr", MEM_WR, 1'b1);
        check("t1_mem_a", MEM_A, 4'd11);
        check("t1_mem_d", MEM_D, 4'd3);
        idle();
        check("t1_mem_en_off", MEM_EN, 1'b0);

        // Read it back through requester 1, two cycles after acceptance.
        cyc(0, 0, 0, 0, 1, 0, 4'd11, 0);
        check("t2_gnt1", g1, 1'b1);
        idle();
        check("t2_rvalid1_early", RVALID1, 1'b0);
        idle();
        check("t2_rvalid1", RVALID1, 1'b1);
        check("t2_rdata1", RDATA1, 4'd3);
        check("t2_rvalid0", RVALID0, 1'b0);
        idle();
        check("t2_rvalid1_off", RVALID1, 1'b0);

        // Contention straight out of reset alternates 0,1,0,...
        do_reset(1);
        seq0 = '0; seq1 = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 4'd2, 0, 1, 0, 4'd5, 0);
            seq0 = {seq0[4:0], g0};
            seq1 = {seq1[4:0], g1};
        end
        check("t3_seq0", seq0, 6'b101010);
        check("t3_seq1", seq1, 6'b010101);
        repeat (3) idle();

        // Lone requester 1 gets every cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 4'(i), 0);
            check("t4_gnt1", g1, 1'b1);
            check("t4_mem_en", MEM_EN, 1'b1);
        end
        repeat (3) idle();

        // Read-after-write on consecutive edges.
        cyc(1, 1, 4'd7, 4'd9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 4'd7, 0);
        idle();
        idle();
        check("t5_rvalid1", RVALID1, 1'b1);
        check("t5_rdata1", RDATA1, 4'd9);
        idle();

        // Reset drops in-flight reads.
        cyc(1, 0, 4'd1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 4'd2, 0);
        do_reset(1);
        check("t6_mem_en", MEM_EN, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_rvalid", {RVALID0, RVALID1}, 2'b00);
            idle();
        end
        cyc(1, 0, 4'd3, 0, 1, 0, 4'd4, 0);
        check("t6_tie_gnt0", g0, 1'b1);
        check("t6_tie_gnt1", g1, 1'b0);
        repeat (3) idle();

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1)
                cyc(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
            else
                cyc(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        end
        RST = 1'b0;
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
